alu_dest_demux: RTL

//  Write-back end of the ALU datapath. The ALU source-A mux selects one of four 16-bit

---
 rtl/alu_dest_demux.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_dest_demux.sv
// alu_dest_demux: write-back end of the ALU datapath.
// Holds a three-entry evaluation stack (Zero/One/Two) and an operand register
// (Three). The ALU result is routed by i_alu_dst. Push and pop shift the stack.
// Depth tracks stack occupancy and saturates at 0 and 3. Sticky flags record
// overflow and underflow. All outputs come straight from registers, so a
// write is visible only after the clock edge that performs it.
module alu_dest_demux #(
  parameter int unsigned WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_write_en,
  input  logic [1:0]       i_alu_dst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear_flags,
  input  logic [WIDTH-1:0] i_result,
  output logic [WIDTH-1:0] o_zero,
  output logic [WIDTH-1:0] o_one,
  output logic [WIDTH-1:0] o_two,
  output logic [WIDTH-1:0] o_three,
  output logic [1:0]       o_depth,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam logic [1:0] DstA       = 2'b00;
  localparam logic [1:0] DstB       = 2'b01;
  localparam logic [1:0] DstC       = 2'b10;
  localparam logic [1:0] DstOperand = 2'b11;
  localparam logic [1:0] DepthMax   = 2'd3;
  localparam logic [1:0] DepthMin   = 2'd0;

  // Operation decoded for the current cycle.
  typedef enum logic [2:0] {
    OpIdle,
    OpWrite,
    OpPush,
    OpPop,
    OpPopWrite,
    OpReplace
  } op_e;

  logic [WIDTH-1:0] r_zero;
  logic [WIDTH-1:0] r_one;
  logic [WIDTH-1:0] r_two;
  logic [WIDTH-1:0] r_three;
  logic [1:0]       r_depth;
  logic             r_overflow;
  logic             r_underflow;

  logic [WIDTH-1:0] w_zero_next;
  logic [WIDTH-1:0] w_one_next;
  logic [WIDTH-1:0] w_two_next;
  logic [WIDTH-1:0] w_three_next;
  logic [1:0]       w_depth_next;
  logic             w_overflow_next;
  logic             w_underflow_next;

  logic             w_eff_push;
  logic             w_set_overflow;
  logic             w_set_underflow;
  op_e              w_op;

  // Push only counts when it actually writes the top of stack.
  assign w_eff_push = i_push & i_write_en & (i_alu_dst == DstA);

  // Decode the effective operation for this edge.
  always_comb begin
    w_op = OpIdle;
    if (w_eff_push && i_pop) begin
      w_op = OpReplace;
    end else if (w_eff_push) begin
      w_op = OpPush;
    end else if (i_pop && i_write_en) begin
      w_op = OpPopWrite;
    end else if (i_pop) begin
      w_op = OpPop;
    end else if (i_write_en) begin
      w_op = OpWrite;
    end
  end

  // Stack and operand register next state.
  always_comb begin
    w_zero_next  = r_zero;
    w_one_next   = r_one;
    w_two_next   = r_two;
    w_three_next = r_three;
    unique case (w_op)
      OpPush: begin
        // Old C falls off the bottom when the stack is already full.
        w_two_next  = r_one;
        w_one_next  = r_zero;
        w_zero_next = i_result;
      end
      OpPop: begin
        w_zero_next = r_one;
        w_one_next  = r_two;
      end
      OpPopWrite: begin
        // Shift first, then the addressed register takes the result.
        w_zero_next = r_one;
        w_one_next  = r_two;
        unique case (i_alu_dst)
          DstA:       w_zero_next  = i_result;
          DstB:       w_one_next   = i_result;
          DstC:       w_two_next   = i_result;
          DstOperand: w_three_next = i_result;
          default:    ;
        endcase
      end
      OpReplace: begin
        w_zero_next = i_result;
      end
      OpWrite: begin
        unique case (i_alu_dst)
          DstA:       w_zero_next  = i_result;
          DstB:       w_one_next   = i_result;
          DstC:       w_two_next   = i_result;
          DstOperand: w_three_next = i_result;
          default:    ;
        endcase
      end
      default: ;
    endcase
  end

  // Depth tracking with saturation; a saturating move raises the matching flag.
  always_comb begin
    w_depth_next    = r_depth;
    w_set_overflow  = 1'b0;
    w_set_underflow = 1'b0;
    unique case (w_op)
      OpPush: begin
        if (r_depth == DepthMax) begin
          w_set_overflow = 1'b1;
        end else begin
          w_depth_next = r_depth + 2'd1;
        end
      end
      OpPop, OpPopWrite: begin
        if (r_depth == DepthMin) begin
          w_set_underflow = 1'b1;
        end else begin
          w_depth_next = r_depth - 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_comb begin
    w_overflow_next  = r_overflow;
    w_underflow_next = r_underflow;
    if (i_clear_flags) begin
      w_overflow_next  = 1'b0;
      w_underflow_next = 1'b0;
    end
    if (w_set_overflow) begin
      w_overflow_next = 1'b1;
    end
    if (w_set_underflow) begin
      w_underflow_next = 1'b1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_zero      <= RST_VAL;
      r_one       <= RST_VAL;
      r_two       <= RST_VAL;
      r_three     <= RST_VAL;
      r_depth     <= DepthMin;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_zero      <= w_zero_next;
      r_one       <= w_one_next;
      r_two       <= w_two_next;
      r_three     <= w_three_next;
      r_depth     <= w_depth_next;
      r_overflow  <= w_overflow_next;
      r_underflow <= w_underflow_next;
    end
  end

  assign o_zero      = r_zero;
  assign o_one       = r_one;
  assign o_two       = r_two;
  assign o_three     = r_three;
  assign o_depth     = r_depth;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule
